// File: rtl/tex_spi_reader.sv
// Texture-ROM SPI read engine: one 1/2/4-lane flash read (0x03/0x3B/0x6B) per request.
// Optional TEX_SPI_CONTINUOUS_EN: CS stays low after a read so the next sequential word skips CMD/ADDR/DUMMY.
module tex_spi_reader #(
  parameter int LANES        = 1,
  parameter int ADDR_BITS    = 24,
  parameter int DATA_BITS    = 24,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_tex_csb,
  output logic                 o_tex_sclk,
  output logic [3:0]           o_tex_io_out,
  output logic [3:0]           o_tex_io_oe,
  input  logic [3:0]           i_tex_io_in
);
  // Handshake: i_start/i_addr are taken on any edge where o_busy==0 (no queueing);
  // o_done is a one-cycle pulse and o_data holds the word until the next o_done.
  localparam logic [7:0] OPCODE = (LANES == 4) ? 8'h6B : (LANES == 2) ? 8'h3B : 8'h03;
  localparam int DUMMY = (LANES == 1) ? 0 : DUMMY_CYCLES;
  localparam int DCYC  = DATA_BITS / LANES;
  localparam int SW    = 8 + ADDR_BITS;
  localparam int CW    = 16;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("tex_spi_reader: LANES must be 1, 2 or 4");
  end
  if (DATA_BITS % LANES != 0) begin : g_bad_data_bits
    $error("tex_spi_reader: DATA_BITS must be a multiple of LANES");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
`ifdef TEX_SPI_CONTINUOUS_EN
    , S_HOLD, S_GAP
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic                   phase_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          shift_out_q;
  logic [DATA_BITS-1:0]   shift_in_q, data_q, shift_next;
  logic [DATA_BITS+LANES-1:0] cat;
  logic [LANES-1:0]       grp;
  logic                   active, bit_end, shifting, released, accept;
  logic                   unused_io;
`ifdef TEX_SPI_CONTINUOUS_EN
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   first_q;
  logic                   seq_hit;
  assign seq_hit = (i_addr == addr_q + ADDR_BITS'(DATA_BITS / 8));
  assign accept  = i_start && (state_q == S_IDLE || state_q == S_HOLD);
`else
  assign accept  = i_start && (state_q == S_IDLE);
`endif

  // Single-lane reads come back on io1 (flash DO); wider reads put the MSB on io[LANES-1].
  assign grp        = (LANES == 1) ? LANES'(i_tex_io_in[1]) : i_tex_io_in[LANES-1:0];
  assign cat        = {shift_in_q, grp};
  assign shift_next = cat[DATA_BITS-1:0];
  assign unused_io  = ^i_tex_io_in;
  assign o_data     = data_q;

  always_comb begin
    state_d      = state_q;
    active       = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    bit_end      = active && phase_q;
    shifting     = (state_q == S_CMD) || (state_q == S_ADDR);
    released     = 1'b0;
    cnt_d        = bit_end ? cnt_q - CW'(1) : cnt_q;
    case (state_q)
      S_IDLE:  if (i_start) begin state_d = S_CMD; cnt_d = CW'(7); end
      S_CMD:   if (bit_end && cnt_q == '0) begin state_d = S_ADDR; cnt_d = CW'(ADDR_BITS - 1); end
      S_ADDR:  if (bit_end && cnt_q == '0) begin
                 if (DUMMY == 0) begin state_d = S_DATA; cnt_d = CW'(DCYC - 1); end
                 else begin state_d = S_DUMMY; cnt_d = CW'(DUMMY - 1); end
               end
      S_DUMMY: if (bit_end && cnt_q == '0) begin state_d = S_DATA; cnt_d = CW'(DCYC - 1); end
`ifdef TEX_SPI_CONTINUOUS_EN
      S_DATA:  if (bit_end && cnt_q == '0) state_d = S_HOLD;
      S_HOLD:  if (i_start) begin
                 if (seq_hit) begin state_d = S_DATA; cnt_d = CW'(DCYC - 1); end
                 else state_d = S_GAP;
               end
      S_GAP:   begin state_d = S_CMD; cnt_d = CW'(7); end
`else
      S_DATA:  if (bit_end && cnt_q == '0) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    released   = state_q inside {S_DUMMY, S_DATA};
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
    o_tex_csb  = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef TEX_SPI_CONTINUOUS_EN
    // The flash may keep driving the next group while parked, so HOLD keeps the lanes released.
    released   = released || (state_q == S_HOLD);
    o_busy     = o_busy && (state_q != S_HOLD);
    o_done     = o_done || (state_q == S_HOLD && first_q);
    o_tex_csb  = o_tex_csb || (state_q == S_GAP);
`endif
    o_tex_sclk      = active && phase_q;
    o_tex_io_out    = {2'b11, 1'b0, shifting && shift_out_q[SW-1]};
    o_tex_io_oe[0]  = (LANES == 1) || !released;
    o_tex_io_oe[1]  = 1'b0;
    o_tex_io_oe[3:2] = (LANES < 4 || shifting) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      shift_out_q <= '0;
      shift_in_q  <= '0;
      data_q      <= '0;
`ifdef TEX_SPI_CONTINUOUS_EN
      addr_q      <= '0;
      first_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= active && !phase_q;
      if (accept) shift_out_q <= {OPCODE, i_addr};
      else if (bit_end && shifting) shift_out_q <= {shift_out_q[SW-2:0], 1'b0};
      if (bit_end && state_q == S_DATA) begin
        shift_in_q <= shift_next;
        if (cnt_q == '0) data_q <= shift_next;
      end
`ifdef TEX_SPI_CONTINUOUS_EN
      if (accept) addr_q <= i_addr;
      first_q <= (state_q == S_DATA) && (state_d == S_HOLD);
`endif
    end
  end
endmodule
